// File: rtl/baud_pkg.sv
// Shared defaults and the divisor record for the fractional baud generator.
package baud_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int FRAC_W_DEF    = 4;
  localparam int OSR_DEF       = 16;
  localparam int RESET_DIV_DEF = 651;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } baud_div_t;

endpackage

// File: rtl/baud_os_div.sv
// Oversampling divider: counts rx ticks and emits one tx tick every OSR of them.
module baud_os_div
  import baud_pkg::*;
#(
  parameter int OSR = OSR_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic step,
  output logic tick_tx
);

  localparam int OS_W = $clog2(OSR);

  logic [OS_W-1:0] os_cnt;

  // step is the same-edge wrap strobe that sets tick_rx, so tick_tx lines up with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      os_cnt  <= '0;
      tick_tx <= 1'b0;
    end else if (!enable) begin
      os_cnt  <= '0;
      tick_tx <= 1'b0;
    end else if (step) begin
      if (os_cnt == OS_W'(OSR - 1)) begin
        os_cnt  <= '0;
        tick_tx <= 1'b1;
      end else begin
        os_cnt  <= os_cnt + OS_W'(1);
        tick_tx <= 1'b0;
      end
    end else begin
      tick_tx <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator with rx oversampling tick and tx bit tick.
// Define BAUD_FRAC_EN to include the fractional accumulator; otherwise div_frac is ignored.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int OSR       = OSR_DEF,
  parameter int RESET_DIV = RESET_DIV_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              rx_resync,
  output logic              tick_rx,
  output logic              tick_tx,
  output logic              div_ack,
  output logic              div_err
);

  typedef struct packed {
    logic [CNT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac_part;
  } div_t;

  div_t             act, pend, req;
  logic             pend_valid;
  logic [CNT_W-1:0] rx_cnt, rx_last;
  logic             load_ok, load_bad, wrap, apply, ext;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;

  assign req     = '{int_part: div_int, frac_part: div_frac};
  assign acc_sum = {1'b0, acc} + {1'b0, act.frac_part};

  // ext holds the carry from the last wrap; it stretches the period now running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (!enable || rx_resync) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (wrap) begin
      {ext, acc} <= acc_sum;
    end
  end
`else
  logic unused_frac;

  assign req         = '{int_part: div_int, frac_part: '0};
  assign ext         = 1'b0;
  assign unused_frac = ^{div_frac, act.frac_part};
`endif

  assign load_ok  = div_load && (div_int >= CNT_W'(2));
  assign load_bad = div_load && !(div_int >= CNT_W'(2));
  assign rx_last  = act.int_part - CNT_W'(1) + CNT_W'(ext);
  assign wrap     = enable && !rx_resync && (rx_cnt == rx_last);
  assign apply    = !enable || wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act        <= '{int_part: CNT_W'(RESET_DIV), frac_part: '0};
      pend       <= '0;
      pend_valid <= 1'b0;
      rx_cnt     <= '0;
      tick_rx    <= 1'b0;
      div_ack    <= 1'b0;
      div_err    <= 1'b0;
    end else begin
      tick_rx <= wrap;
      div_err <= load_bad;
      div_ack <= 1'b0;

      if (!enable || rx_resync || wrap)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + CNT_W'(1);

      // a load arriving on the apply edge wins over an older pending value
      if (apply && (load_ok || pend_valid)) begin
        act        <= load_ok ? req : pend;
        pend_valid <= 1'b0;
        div_ack    <= 1'b1;
      end else if (load_ok) begin
        pend       <= req;
        pend_valid <= 1'b1;
      end
    end
  end

  baud_os_div #(
    .OSR (OSR)
  ) u_os_div (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .step    (wrap),
    .tick_tx (tick_tx)
  );

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac against an arithmetic period model.
module tb_baud_gen_frac;

  localparam int RESET_DIV = 651;
  localparam int OSR       = 16;
  localparam int FRAC_W    = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        rx_resync = 1'b0;
  logic        tick_rx, tick_tx, div_ack, div_err;

  int vectors = 0;
  int miscompares = 0;

  baud_gen_frac dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .div_load  (div_load),
    .rx_resync (rx_resync),
    .tick_rx   (tick_rx),
    .tick_tx   (tick_tx),
    .div_ack   (div_ack),
    .div_err   (div_err)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Period j (1-based, counted from enable) = int + carry produced at wrap j-1.
  function automatic int model_period(input int iv, input int fv, input int j);
    int f;
`ifdef BAUD_FRAC_EN
    f = fv;
`else
    f = 0;
`endif
    if (j == 1) return iv;
    return iv + ((j - 1) * f) / (1 << FRAC_W) - ((j - 2) * f) / (1 << FRAC_W);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rx(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick_rx !== 1'b1 && n <= max);
  endtask

  task automatic do_load(input int iv, input int fv);
    div_int  = 16'(iv);
    div_frac = 4'(fv);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  // Disable, load a divisor while idle, enable and consume the first tick.
  task automatic start_run(input int iv, input int fv);
    int n;
    enable = 1'b0;
    step();
    do_load(iv, fv);
    enable = 1'b1;
    wait_rx(iv + 4, n);
  endtask

  task automatic test_reset();
    int n;
    repeat (2) step();
    vectors += 4;
    if (tick_rx !== 1'b0) begin miscompares++; $display("FAIL reset_tick_rx: got %b expected 0", tick_rx); end
    if (tick_tx !== 1'b0) begin miscompares++; $display("FAIL reset_tick_tx: got %b expected 0", tick_tx); end
    if (div_ack !== 1'b0) begin miscompares++; $display("FAIL reset_div_ack: got %b expected 0", div_ack); end
    if (div_err !== 1'b0) begin miscompares++; $display("FAIL reset_div_err: got %b expected 0", div_err); end
    enable = 1'b1;
    reset  = 1'b1;
    wait_rx(RESET_DIV + 20, n);
    vectors++;
    if (n != RESET_DIV) begin miscompares++; $display("FAIL reset_first_tick: got %0d expected %0d", n, RESET_DIV); end
  endtask

  task automatic test_basic();
    int edges, rxc;
    enable = 1'b0;
    step();
    do_load(10, 0);
    vectors++;
    if (div_ack !== 1'b1) begin miscompares++; $display("FAIL basic_idle_ack: got %b expected 1", div_ack); end
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      edges = 0;
      rxc = 0;
      do begin
        step();
        edges++;
        if (tick_rx === 1'b1) rxc++;
      end while (tick_tx !== 1'b1 && edges <= 400);
      vectors += 2;
      if (edges != 10 * OSR) begin miscompares++; $display("FAIL basic_tx_period: got %0d expected %0d", edges, 10 * OSR); end
      if (rxc != OSR) begin miscompares++; $display("FAIL basic_rx_per_tx: got %0d expected %0d", rxc, OSR); end
    end
  endtask

  task automatic test_frac();
    int n, sum, exp_sum;
    enable = 1'b0;
    step();
    do_load(10, 8);
    enable = 1'b1;
    sum = 0;
    for (int j = 1; j <= 17; j++) begin
      wait_rx(40, n);
      vectors++;
      if (n != model_period(10, 8, j)) begin
        miscompares++;
        $display("FAIL frac_period[%0d]: got %0d expected %0d", j, n, model_period(10, 8, j));
      end
      if (j >= 2) sum += n;
    end
`ifdef BAUD_FRAC_EN
    exp_sum = 168;
`else
    exp_sum = 160;
`endif
    vectors++;
    if (sum != exp_sum) begin miscompares++; $display("FAIL frac_16_periods: got %0d expected %0d", sum, exp_sum); end
  endtask

  task automatic test_random();
    int n, iv, fv;
    for (int it = 0; it < 6; it++) begin
      iv = $urandom_range(2, 24);
      fv = $urandom_range(0, 15);
      enable = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      do_load(iv, fv);
      enable = 1'b1;
      for (int j = 1; j <= 17; j++) begin
        wait_rx(60, n);
        vectors++;
        if (n != model_period(iv, fv, j)) begin
          miscompares++;
          $display("FAIL rand_period int=%0d frac=%0d [%0d]: got %0d expected %0d", iv, fv, j, n, model_period(iv, fv, j));
        end
      end
    end
  endtask

  task automatic test_err();
    int n;
    start_run(10, 0);
    do_load($urandom_range(0, 1), 0);
    vectors += 2;
    if (div_err !== 1'b1) begin miscompares++; $display("FAIL err_pulse: got %b expected 1", div_err); end
    if (div_ack !== 1'b0) begin miscompares++; $display("FAIL err_no_ack: got %b expected 0", div_ack); end
    wait_rx(30, n);
    vectors += 2;
    if (n != 9) begin miscompares++; $display("FAIL err_period_rest: got %0d expected 9", n); end
    if (div_ack !== 1'b0) begin miscompares++; $display("FAIL err_ack_at_wrap: got %b expected 0", div_ack); end
    wait_rx(30, n);
    vectors++;
    if (n != 10) begin miscompares++; $display("FAIL err_period_next: got %0d expected 10", n); end
  endtask

  task automatic test_load_mid();
    int n;
    start_run(10, 0);
    repeat (3) step();
    do_load(20, 0);
    vectors++;
    if (div_ack !== 1'b0) begin miscompares++; $display("FAIL mid_early_ack: got %b expected 0", div_ack); end
    wait_rx(30, n);
    vectors += 3;
    if (n != 6) begin miscompares++; $display("FAIL mid_old_period: got %0d expected 6", n); end
    if (div_ack !== 1'b1) begin miscompares++; $display("FAIL mid_ack_at_tick: got %b expected 1", div_ack); end
    wait_rx(40, n);
    if (n != 20) begin miscompares++; $display("FAIL mid_new_period: got %0d expected 20", n); end
    // two loads in one period: only the later one may apply
    step();
    do_load(15, 0);
    step();
    do_load(25, 0);
    wait_rx(40, n);
    vectors += 3;
    if (n != 16) begin miscompares++; $display("FAIL twoload_rest: got %0d expected 16", n); end
    if (div_ack !== 1'b1) begin miscompares++; $display("FAIL twoload_ack: got %b expected 1", div_ack); end
    wait_rx(40, n);
    if (n != 25) begin miscompares++; $display("FAIL twoload_period: got %0d expected 25", n); end
    // load on the very wrap edge takes effect at that wrap
    repeat (24) step();
    do_load(12, 0);
    vectors += 3;
    if (tick_rx !== 1'b1) begin miscompares++; $display("FAIL coinc_tick: got %b expected 1", tick_rx); end
    if (div_ack !== 1'b1) begin miscompares++; $display("FAIL coinc_ack: got %b expected 1", div_ack); end
    wait_rx(40, n);
    if (n != 12) begin miscompares++; $display("FAIL coinc_period: got %0d expected 12", n); end
  endtask

  task automatic test_resync();
    int n, rxc, edges;
    start_run(10, 0);
    rxc = 1;
    repeat (5) step();
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    vectors++;
    if (tick_rx !== 1'b0) begin miscompares++; $display("FAIL resync_mid_tick: got %b expected 0", tick_rx); end
    wait_rx(30, n);
    rxc++;
    vectors++;
    if (n != 10) begin miscompares++; $display("FAIL resync_mid_period: got %0d expected 10", n); end
    repeat (9) step();
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    vectors++;
    if (tick_rx !== 1'b0) begin miscompares++; $display("FAIL resync_wrap_suppress: got %b expected 0", tick_rx); end
    wait_rx(30, n);
    rxc++;
    vectors++;
    if (n != 10) begin miscompares++; $display("FAIL resync_wrap_period: got %0d expected 10", n); end
    edges = 0;
    do begin
      step();
      edges++;
      if (tick_rx === 1'b1) rxc++;
    end while (tick_tx !== 1'b1 && edges <= 300);
    vectors += 2;
    if (rxc != OSR) begin miscompares++; $display("FAIL resync_osr_kept: got %0d expected %0d", rxc, OSR); end
    if (tick_rx !== 1'b1) begin miscompares++; $display("FAIL resync_tx_align: got %b expected 1", tick_rx); end
  endtask

  task automatic test_reset_mid();
    int n;
    start_run(10, 0);
    wait_rx(30, n);
    reset = 1'b0;
    #1;
    vectors += 2;
    if (tick_rx !== 1'b0) begin miscompares++; $display("FAIL rstmid_tick_rx: got %b expected 0", tick_rx); end
    if (div_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_div_ack: got %b expected 0", div_ack); end
    repeat (2) step();
    reset = 1'b1;
    wait_rx(RESET_DIV + 20, n);
    vectors++;
    if (n != RESET_DIV) begin miscompares++; $display("FAIL rstmid_first_tick: got %0d expected %0d", n, RESET_DIV); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_random();
    test_err();
    test_load_mid();
    test_resync();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
